instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 99 +++++++++
 tb/tb_instr_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS-style instruction fields into 32-bit words and writes them to instruction memory
module instr_encoder #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    mnem,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    input  logic          last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [AW:0]   count,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, ENC, WR, DONE} state_t;
    state_t state, nxt;
    logic [3:0]  mnem_q;
    logic [4:0]  rs_q, rt_q, rd_q;
    logic [15:0] imm_q;
    logic [25:0] tgt_q;
    logic        last_q;
    logic [31:0] enc;
    logic        accept, legal;
    assign accept   = in_valid && in_ready;
    assign legal    = mnem < 4'd13;
    assign in_ready = state == IDLE;
    assign mem_we   = state == WR;
    assign done     = state == DONE;
    // pointer and count advance together, so the pointer is the low bits of count
    assign mem_addr = count[AW-1:0];
    always_comb begin
        enc = '0;
        case (mnem_q)
            4'd0:  enc = {6'h00, rs_q, rt_q, rd_q, 5'd0, 6'h20};
            4'd1:  enc = {6'h00, rs_q, rt_q, rd_q, 5'd0, 6'h22};
            4'd2:  enc = {6'h00, rs_q, rt_q, rd_q, 5'd0, 6'h24};
            4'd3:  enc = {6'h00, rs_q, rt_q, rd_q, 5'd0, 6'h25};
            4'd4:  enc = {6'h00, rs_q, rt_q, rd_q, 5'd0, 6'h27};
            4'd5:  enc = {6'h00, rs_q, rt_q, rd_q, 5'd0, 6'h2a};
            4'd6:  enc = {6'h00, rs_q, 15'd0, 6'h08};
            4'd7:  enc = {6'h23, rs_q, rt_q, imm_q};
            4'd8:  enc = {6'h2b, rs_q, rt_q, imm_q};
            4'd9:  enc = {6'h04, rs_q, rt_q, imm_q};
            4'd10: enc = {6'h08, rs_q, rt_q, imm_q};
            4'd11: enc = {6'h02, tgt_q};
            4'd12: enc = {6'h03, tgt_q};
            default: enc = '0;
        endcase
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = (accept && legal) ? ENC : IDLE;
            ENC:  nxt = WR;
            WR:   nxt = (last_q || &count[AW-1:0]) ? DONE : IDLE;
            DONE: nxt = DONE;
            default: nxt = IDLE;
        endcase
        if (clear) nxt = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            err       <= 1'b0;
            mem_wdata <= '0;
        end else begin
            state <= nxt;
            if (clear) begin
                count <= '0;
                err   <= 1'b0;
            end else begin
                if (accept && !legal) err <= 1'b1;
                if (state == ENC) mem_wdata <= enc;
                if (state == WR) count <= count + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (accept && !clear) begin
            mnem_q <= mnem;
            rs_q   <= rs;
            rt_q   <= rt;
            rd_q   <= rd;
            imm_q  <= imm;
            tgt_q  <= target;
            last_q <= last;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder (AW=8 and AW=2 instances)
module tb_instr_encoder;
    typedef struct packed {
        logic [3:0]  m;
        logic [4:0]  s;
        logic [4:0]  t;
        logic [4:0]  d;
        logic [15:0] i;
        logic [25:0] g;
        logic [31:0] w;
    } vec_t;

    logic clk = 0, rst = 0, clear = 0, in_valid = 0, in_valid2 = 0, last = 0;
    logic [3:0]  mnem = 0;
    logic [4:0]  rs = 0, rt = 0, rd = 0;
    logic [15:0] imm = 0;
    logic [25:0] target = 0;
    logic        in_ready, mem_we, done, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  count;
    logic        in_ready2, mem_we2, done2, err2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_wdata2;
    logic [2:0]  count2;
    int total = 0, bad = 0;
    logic [39:0] q1[$], q2[$];
    logic [39:0] e1, e2;

    vec_t tbl [9] = '{
        '{4'd0,  5'd1,  5'd2, 5'd3, 16'h1234, 26'h2AAAAAA, 32'h00221820},
        '{4'd1,  5'd1,  5'd2, 5'd3, 16'h1234, 26'h2AAAAAA, 32'h00221822},
        '{4'd2,  5'd1,  5'd2, 5'd3, 16'h1234, 26'h2AAAAAA, 32'h00221824},
        '{4'd3,  5'd1,  5'd2, 5'd3, 16'h1234, 26'h2AAAAAA, 32'h00221825},
        '{4'd4,  5'd1,  5'd2, 5'd3, 16'h1234, 26'h2AAAAAA, 32'h00221827},
        '{4'd5,  5'd1,  5'd2, 5'd3, 16'h1234, 26'h2AAAAAA, 32'h0022182A},
        '{4'd6,  5'd31, 5'd2, 5'd3, 16'h1234, 26'h2AAAAAA, 32'h03E00008},
        '{4'd8,  5'd29, 5'd4, 5'd3, 16'h0010, 26'h2AAAAAA, 32'hAFA40010},
        '{4'd11, 5'd1,  5'd2, 5'd3, 16'h1234, 26'h3FFFFFF, 32'h0BFFFFFF}
    };

    instr_encoder #(.AW(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target), .last(last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
        .done(done), .err(err)
    );

    instr_encoder #(.AW(2)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid2), .in_ready(in_ready2),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target), .last(last),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .count(count2),
        .done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr %h data %h", mem_addr, mem_wdata);
            end else begin
                e1 = q1.pop_front();
                check("wr_addr", {24'd0, mem_addr}, {24'd0, e1[39:32]});
                check("wr_data", mem_wdata, e1[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (mem_we2 === 1'b1) begin
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write2: addr %h data %h", mem_addr2, mem_wdata2);
            end else begin
                e2 = q2.pop_front();
                check("wr2_addr", {30'd0, mem_addr2}, {24'd0, e2[39:32]});
                check("wr2_data", mem_wdata2, e2[31:0]);
            end
        end
    end

    task automatic send(input bit two, input vec_t v, input logic l);
        int n = 0;
        @(negedge clk);
        while (!(two ? in_ready2 : in_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", n);
        end
        mnem = v.m; rs = v.s; rt = v.t; rd = v.d; imm = v.i; target = v.g; last = l;
        if (two) in_valid2 = 1; else in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        in_valid2 = 0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
    endtask

    initial begin
        vec_t v;
        #1 rst = 1;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_count", 32'(count), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        repeat (2) @(negedge clk);
        rst = 0;

        // every opcode class, consecutive addresses
        for (int k = 0; k < 9; k++) begin
            q1.push_back({8'(k), tbl[k].w});
            send(0, tbl[k], 0);
        end
        repeat (3) @(negedge clk);
        check("table_count", 32'(count), 9);
        check("table_in_ready", 32'(in_ready), 1);
        check("table_done", 32'(done), 0);

        pulse_clear();
        check("clear_count", 32'(count), 0);
        q1.push_back({8'd0, 32'h8C080004});
        send(0, '{4'd7, 5'd0, 5'd8, 5'd0, 16'h0004, 26'd0, 32'd0}, 0);
        q1.push_back({8'd1, 32'h0C000010});
        send(0, '{4'd12, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0000010, 32'd0}, 1);
        repeat (3) @(negedge clk);
        check("last_done", 32'(done), 1);
        check("last_in_ready", 32'(in_ready), 0);
        check("last_count", 32'(count), 2);
        repeat (3) @(negedge clk);
        check("done_holds", 32'(done), 1);

        pulse_clear();
        check("clear_done", 32'(done), 0);
        send(0, '{4'd14, 5'd1, 5'd2, 5'd3, 16'h1111, 26'd5, 32'd0}, 0);
        check("illegal_err", 32'(err), 1);
        check("illegal_in_ready", 32'(in_ready), 1);
        repeat (3) @(negedge clk);
        check("illegal_count", 32'(count), 0);
        q1.push_back({8'd0, 32'h1085FFFF});
        send(0, '{4'd9, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'd0, 32'd0}, 0);
        repeat (3) @(negedge clk);
        check("beq_count", 32'(count), 1);
        check("err_sticky", 32'(err), 1);

        // clear while in ENC drops the pending word
        send(0, tbl[0], 0);
        clear = 1;
        @(posedge clk);
        #1 clear = 0;
        check("clr_enc_in_ready", 32'(in_ready), 1);
        check("clr_enc_count", 32'(count), 0);
        check("clr_enc_err", 32'(err), 0);
        repeat (4) @(negedge clk);

        // rst during WR
        send(0, tbl[1], 0);
        @(posedge clk);
        #1;
        check("wr_mem_we", 32'(mem_we), 1);
        check("wr_wdata_pre", mem_wdata, 32'h00221822);
        #1 rst = 1;
        #1;
        check("arst_mem_we", 32'(mem_we), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_mem_wdata", mem_wdata, 0);
        check("arst_mem_addr", 32'(mem_addr), 0);
        check("arst_count", 32'(count), 0);
        check("arst_done", 32'(done), 0);
        @(negedge clk);
        rst = 0;

        // AW=2: memory fills after four words
        for (int k = 0; k < 4; k++) begin
            v = '{4'd10, 5'd0, 5'd1, 5'd0, 16'(k), 26'd0, 32'd0};
            q2.push_back({8'(k), 32'h20010000 | 32'(k)});
            send(1, v, 0);
            if (k == 2) begin
                repeat (3) @(negedge clk);
                check("aw2_not_done", 32'(done2), 0);
            end
        end
        repeat (3) @(negedge clk);
        check("aw2_done", 32'(done2), 1);
        check("aw2_count", 32'(count2), 4);
        check("aw2_in_ready", 32'(in_ready2), 0);

        repeat (3) @(negedge clk);
        check("q1_drained", 32'(q1.size()), 0);
        check("q2_drained", 32'(q2.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
